// File: rtl/scan_sequencer.sv
// Channel scan sequencer feeding a 3-to-8 decoder (enable + select).
// Ports: clk, rst, start, stop, mode, dwell, mask -> en, sel, busy, done, err.
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  output logic               en,
  output logic [2:0]         sel,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic IDLE = 1'b0;
  localparam logic SCAN = 1'b1;

  logic               state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] ldwell;
  logic [DWELL_W-1:0] last;
  logic [7:0]         lmask;
  logic               lmode;

  logic [2:0] in_low;
  logic [2:0] lm_low;
  logic [2:0] nxt;
  logic       nxt_ok;

  assign last = ldwell - DWELL_W'(1);

  // Lowest set bit of the incoming mask, lowest set bit of the
  // latched mask, and the next latched bit strictly above sel.
  // Downward loops let the lowest qualifying index win.
  always_comb begin
    in_low = 3'd0;
    lm_low = 3'd0;
    nxt    = 3'd0;
    nxt_ok = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) in_low = 3'(i);
      if (lmask[i]) lm_low = 3'(i);
      if (lmask[i] && (3'(i) > sel)) begin
        nxt    = 3'(i);
        nxt_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      en     <= 1'b0;
      sel    <= 3'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      cnt    <= '0;
      ldwell <= DWELL_W'(1);
      lmask  <= 8'd0;
      lmode  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (mask != 8'd0) begin
              lmask  <= mask;
              lmode  <= mode;
              ldwell <= (dwell == '0) ? DWELL_W'(1) : dwell;
              sel    <= in_low;
              en     <= 1'b1;
              busy   <= 1'b1;
              cnt    <= '0;
              state  <= SCAN;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (stop) begin
            state <= IDLE;
            en    <= 1'b0;
            sel   <= 3'd0;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == last) begin
            cnt <= '0;
            if (nxt_ok) begin
              sel <= nxt;
            end else if (!lmode) begin
              sel <= lm_low;
            end else begin
              state <= IDLE;
              en    <= 1'b0;
              sel   <= 3'd0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            cnt <= cnt + DWELL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed self-checking bench for scan_sequencer.
// Drives and samples 1ns after each rising edge.
module tb_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] dwell;
  logic [7:0] mask;
  logic       en;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  scan_sequencer #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .mode  (mode),
    .dwell (dwell),
    .mask  (mask),
    .en    (en),
    .sel   (sel),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_en"}, int'(en), 0);
    chk({tag, "_sel"}, int'(sel), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  int exp1 [8] = '{0, 0, 2, 2, 5, 5, 7, 7};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    mode = 1'b0;
    dwell = 8'd1;
    mask = 8'd0;
    #3;
    idle_chk("rst");
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    step();
    rst = 1'b0;
    step();

    // 1: single pass over A5, dwell 2
    mask = 8'hA5; dwell = 8'd2; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_sel", int'(sel), exp1[i]);
      chk("t1_en", int'(en), 1);
      chk("t1_done", int'(done), 0);
      step();
    end
    idle_chk("t1_end");
    chk("t1_donep", int'(done), 1);
    step();
    chk("t1_done0", int'(done), 0);

    // 2: continuous over 81, dwell 1
    mask = 8'h81; dwell = 8'd1; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t2_sel", int'(sel), (i % 2 == 0) ? 0 : 7);
      chk("t2_en", int'(en), 1);
      chk("t2_done", int'(done), 0);
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    idle_chk("t2_stop");

    // 3: empty mask
    mask = 8'h00; start = 1'b1;
    step();
    start = 1'b0;
    chk("t3_err", int'(err), 1);
    idle_chk("t3");
    chk("t3_done", int'(done), 0);
    step();
    chk("t3_err0", int'(err), 0);

    // start with stop: stop wins, no err even with empty mask
    start = 1'b1; stop = 1'b1;
    step();
    chk("ss_err", int'(err), 0);
    mask = 8'hFF;
    step();
    start = 1'b0; stop = 1'b0;
    idle_chk("ss");

    // 4: FF dwell 3 continuous, stop on 2nd cycle of sel=4
    mask = 8'hFF; dwell = 8'd3; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 13; i++) step();
    chk("t4_sel4", int'(sel), 4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    idle_chk("t4");
    chk("t4_done", int'(done), 0);

    // 5: dwell 0 treated as 1
    mask = 8'h0C; dwell = 8'd0; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_sel2", int'(sel), 2);
    step();
    chk("t5_sel3", int'(sel), 3);
    chk("t5_en", int'(en), 1);
    step();
    chk("t5_done", int'(done), 1);
    idle_chk("t5_end");

    // 6: async reset mid-scan at sel=3
    mask = 8'hFF; dwell = 8'd4; mode = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("t6_sel3", int'(sel), 3);
    #2 rst = 1'b1;
    #1;
    idle_chk("t6_rst");
    chk("t6_done", int'(done), 0);
    #2 rst = 1'b0;
    step();
    idle_chk("t6_wait");
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_sel0", int'(sel), 0);
    chk("t6_en", int'(en), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // 7: mask change during SCAN ignored
    mask = 8'hFF; dwell = 8'd1; mode = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    mask = 8'h01;
    for (int i = 0; i < 8; i++) begin
      chk("t7_sel", int'(sel), i);
      chk("t7_busy", int'(busy), 1);
      step();
    end
    chk("t7_done", int'(done), 1);
    chk("t7_en", int'(en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
